// File: rtl/axi4_pkg.sv
// Shared definitions for the AXI4 memory responder: burst and response
// encodings, the controller state set, and a burst legality helper.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    AW_ACK,
    WDATA,
    WRESP,
    AR_ACK,
    RDATA
  } state_e;

  // Only FIXED and INCR are honoured; WRAP runs as INCR but still flags an error.
  function automatic logic burst_bad(input logic [1:0] burst);
    return (burst == BURST_WRAP) || (burst == 2'd3);
  endfunction

endpackage

// File: rtl/axi4_slave_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module axi4_slave_ram #(
  parameter int DATA_W = 256,
  parameter int AW     = 10
) (
  input  logic                clk,
  input  logic [AW-1:0]       addr,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 memory endpoint standing in for the DDR controller: serves one burst at
// a time, alternating between write and read when both are requested together.
module axi4_slave_mem
  import axi4_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 30,
  parameter int ID_W   = 4,
  parameter int MEM_AW = 10
) (
  input  logic                axi_clk,
  input  logic                axi_resetn,
  input  logic [ID_W-1:0]     axi_awid,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [3:0]          axi_awlen,
  input  logic [2:0]          axi_awsize,
  input  logic [1:0]          axi_awburst,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic [ID_W-1:0]     axi_bid,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  input  logic [ID_W-1:0]     axi_arid,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [3:0]          axi_arlen,
  input  logic [2:0]          axi_arsize,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [ID_W-1:0]     axi_rid,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready
);

  localparam int         B         = $clog2(DATA_W/8);
  localparam logic [2:0] SIZE_FULL = 3'(B);

  state_e              state, state_nxt;
  logic                read_prio;
  logic [ID_W-1:0]     id_q;
  logic [MEM_AW-1:0]   addr_q, addr_adv, ram_addr;
  logic [3:0]          len_q, cnt_q;
  logic                fixed_q, err_q;
  logic                w_hs, r_hs, last_beat;
  logic [DATA_W-1:0]   ram_q;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^{axi_awaddr, axi_araddr};

  assign last_beat = (cnt_q == len_q);
  assign w_hs      = (state == WDATA) && axi_wvalid;
  assign r_hs      = (state == RDATA) && axi_rready;
  assign addr_adv  = fixed_q ? addr_q : addr_q + MEM_AW'(1);

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bid     = '0;
    axi_bresp   = RESP_OKAY;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rid     = '0;
    axi_rdata   = '0;
    axi_rresp   = RESP_OKAY;
    axi_rlast   = 1'b0;
    case (state)
      IDLE: begin
        if (axi_awvalid && (!axi_arvalid || !read_prio)) state_nxt = AW_ACK;
        else if (axi_arvalid)                            state_nxt = AR_ACK;
      end
      AW_ACK: begin
        axi_awready = 1'b1;
        state_nxt   = WDATA;
      end
      WDATA: begin
        axi_wready = 1'b1;
        if (w_hs && last_beat) state_nxt = WRESP;
      end
      WRESP: begin
        axi_bvalid = 1'b1;
        axi_bid    = id_q;
        axi_bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        if (axi_bready) state_nxt = IDLE;
      end
      AR_ACK: begin
        axi_arready = 1'b1;
        state_nxt   = RDATA;
      end
      RDATA: begin
        axi_rvalid = 1'b1;
        axi_rid    = id_q;
        axi_rdata  = ram_q;
        axi_rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
        axi_rlast  = last_beat;
        if (r_hs && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read prefetch: the RAM address runs one beat ahead so beat N+1 is ready
  // the cycle after beat N is accepted; a stalled beat simply re-reads its word.
  always_comb begin
    ram_addr = addr_q;
    case (state)
      AR_ACK:  ram_addr = axi_araddr[MEM_AW+B-1:B];
      RDATA:   if (r_hs) ram_addr = addr_adv;
      default: ram_addr = addr_q;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (!axi_resetn) begin
      read_prio <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (state_nxt == AW_ACK)      read_prio <= 1'b1;
          else if (state_nxt == AR_ACK) read_prio <= 1'b0;
        end
        AW_ACK: begin
          id_q    <= axi_awid;
          addr_q  <= axi_awaddr[MEM_AW+B-1:B];
          len_q   <= axi_awlen;
          cnt_q   <= '0;
          fixed_q <= (axi_awburst == BURST_FIXED);
          err_q   <= burst_bad(axi_awburst) || (axi_awsize != SIZE_FULL);
        end
        AR_ACK: begin
          id_q    <= axi_arid;
          addr_q  <= axi_araddr[MEM_AW+B-1:B];
          len_q   <= axi_arlen;
          cnt_q   <= '0;
          fixed_q <= (axi_arburst == BURST_FIXED);
          err_q   <= burst_bad(axi_arburst) || (axi_arsize != SIZE_FULL);
        end
        WDATA: begin
          if (w_hs) begin
            addr_q <= addr_adv;
            cnt_q  <= cnt_q + 4'd1;
            if (axi_wlast != last_beat) err_q <= 1'b1;
          end
        end
        RDATA: begin
          if (r_hs) begin
            addr_q <= addr_adv;
            cnt_q  <= cnt_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  axi4_slave_ram #(
    .DATA_W (DATA_W),
    .AW     (MEM_AW)
  ) u_ram (
    .clk   (axi_clk),
    .addr  (ram_addr),
    .we    (w_hs),
    .be    (axi_wstrb),
    .wdata (axi_wdata),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Randomised self-checking bench for axi4_slave_mem against a word-array memory model.
module tb_axi4_slave_mem;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 30;
  localparam int ID_W   = 4;
  localparam int MEM_AW = 10;
  localparam int STRB_W = DATA_W/8;
  localparam int WORDS  = 1 << MEM_AW;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [ID_W-1:0] awid = '0, arid = '0, bid, rid;
  logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
  logic [3:0] awlen = '0, arlen = '0;
  logic [2:0] awsize = 3'd5, arsize = 3'd5;
  logic [1:0] awburst = 2'd1, arburst = 2'd1, bresp, rresp;
  logic awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic bready = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic [DATA_W-1:0] wdata = '0, rdata;
  logic [STRB_W-1:0] wstrb = '0;

  always #5 clk = ~clk;

  axi4_slave_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .MEM_AW(MEM_AW)) dut (
    .axi_clk(clk), .axi_resetn(resetn),
    .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize),
    .axi_awburst(awburst), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid),
    .axi_wready(wready), .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid),
    .axi_bready(bready), .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen),
    .axi_arsize(arsize), .axi_arburst(arburst), .axi_arvalid(arvalid),
    .axi_arready(arready), .axi_rid(rid), .axi_rdata(rdata), .axi_rresp(rresp),
    .axi_rlast(rlast), .axi_rvalid(rvalid), .axi_rready(rready)
  );

  int checks = 0, passes = 0, cyc = 0;
  logic [DATA_W-1:0] model [WORDS];
  logic [DATA_W-1:0] wbuf [16];
  logic [STRB_W-1:0] sbuf [16];
  logic [DATA_W-1:0] rbuf [32];
  logic [1:0]        rrbuf [32];
  logic              rlbuf [32];
  int t_aw, t_wready, t_after_w, t_bvalid, t_ar, t_rvalid, nbeats, unstable;
  logic [1:0] got_bresp;
  logic [ID_W-1:0] got_bid, got_rid;
  bit ok;

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  function automatic logic [ADDR_W-1:0] make_addr(input logic [MEM_AW-1:0] word);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom);
    a[MEM_AW+4:5] = word;
    return a;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [1:0] burst, input logic [2:0] size,
                                          input int early, input int len);
    return (burst >= 2 || size != 3'd5 || (early >= 0 && early != len)) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [MEM_AW-1:0] beat_word(input logic [MEM_AW-1:0] start,
                                                  input logic [1:0] burst, input int b);
    return (burst == 2'd0) ? start : MEM_AW'(int'(start) + b);
  endfunction

  task automatic fill(input int len, input bit rand_strb);
    for (int b = 0; b <= len; b++) begin
      for (int k = 0; k < DATA_W/32; k++) wbuf[b][k*32 +: 32] = $urandom;
      sbuf[b] = rand_strb ? STRB_W'($urandom) : '1;
    end
  endtask

  task automatic model_write(input logic [MEM_AW-1:0] word, input int len, input logic [1:0] burst);
    for (int b = 0; b <= len; b++)
      for (int i = 0; i < STRB_W; i++)
        if (sbuf[b][i]) model[beat_word(word, burst, b)][i*8 +: 8] = wbuf[b][i*8 +: 8];
  endtask

  task automatic aw_phase(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a, input int len,
                          input logic [1:0] burst, input logic [2:0] size);
    awid = id; awaddr = a; awlen = 4'(len); awburst = burst; awsize = size; awvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (awready) begin t_aw = cyc; ok = 1; end
      tick();
    end
    awvalid = 1'b0;
  endtask

  task automatic w_phase(input int len, input int early);
    int beat = 0;
    t_wready = -1;
    wvalid = 1'b1;
    for (int i = 0; i < 200 && beat <= len; i++) begin
      wdata = wbuf[beat]; wstrb = sbuf[beat];
      wlast = (early >= 0) ? (beat == early) : (beat == len);
      if (wready) begin
        if (t_wready < 0) t_wready = cyc;
        beat++;
      end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    ok = (beat > len);
  endtask

  task automatic b_phase(input bit toggle);
    logic [1:0] hr = '0;
    logic [ID_W-1:0] hi = '0;
    bit held = 0, done = 0;
    unstable = 0; t_bvalid = -1;
    for (int i = 0; i < 60 && !done; i++) begin
      bready = toggle ? (i % 2 == 1) : 1'b1;
      if (bvalid) begin
        if (t_bvalid < 0) t_bvalid = cyc;
        if (held && (bresp !== hr || bid !== hi)) unstable++;
        if (bready) begin got_bresp = bresp; got_bid = bid; done = 1; end
      end
      held = bvalid && !bready; hr = bresp; hi = bid;
      tick();
    end
    bready = 1'b0;
    ok = done;
  endtask

  task automatic ar_phase(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a, input int len,
                          input logic [1:0] burst, input logic [2:0] size);
    arid = id; araddr = a; arlen = 4'(len); arburst = burst; arsize = size; arvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (arready) begin t_ar = cyc; ok = 1; end
      tick();
    end
    arvalid = 1'b0;
  endtask

  task automatic r_phase(input bit toggle);
    logic [DATA_W-1:0] hd = '0;
    logic [1:0] hr = '0;
    logic hl = 1'b0;
    bit held = 0, done = 0;
    nbeats = 0; unstable = 0; t_rvalid = -1;
    for (int i = 0; i < 300 && !done && nbeats < 20; i++) begin
      rready = toggle ? (i % 2 == 1) : 1'b1;
      if (rvalid) begin
        if (t_rvalid < 0) begin t_rvalid = cyc; got_rid = rid; end
        if (held && (rdata !== hd || rresp !== hr || rlast !== hl)) unstable++;
        if (rready) begin
          rbuf[nbeats] = rdata; rrbuf[nbeats] = rresp; rlbuf[nbeats] = rlast;
          nbeats++;
          done = rlast;
        end
      end
      held = rvalid && !rready; hd = rdata; hr = rresp; hl = rlast;
      tick();
    end
    rready = 1'b0;
    ok = done;
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input int early,
                          input bit toggle);
    bit all;
    aw_phase(id, a, len, burst, size); all = ok;
    w_phase(len, early);               all &= ok;
    t_after_w = cyc;
    b_phase(toggle);                   all &= ok;
    model_write(a[MEM_AW+4:5], len, burst);
    ok = all;
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a, input int len,
                         input logic [1:0] burst, input logic [2:0] size, input bit toggle);
    bit all;
    ar_phase(id, a, len, burst, size); all = ok;
    r_phase(toggle);                   all &= ok;
    ok = all;
  endtask

  // Reads back a burst and compares every beat against the model.
  task automatic read_and_compare(input string name, input logic [ID_W-1:0] id,
                                  input logic [MEM_AW-1:0] word, input int len,
                                  input logic [1:0] burst, input logic [1:0] resp, input bit toggle);
    do_read(id, make_addr(word), len, burst, 3'd5, toggle);
    checks++; if (!ok || nbeats != len + 1) $display("FAIL %s_beats: got %0d beats ok=%0b, expected %0d", name, nbeats, ok, len + 1); else passes++;
    checks++; if (got_rid !== id) $display("FAIL %s_rid: got %0h expected %0h", name, got_rid, id); else passes++;
    for (int b = 0; b <= len && b < nbeats; b++) begin
      checks++;
      if (rbuf[b] !== model[beat_word(word, burst, b)] || rrbuf[b] !== resp || rlbuf[b] !== (b == len))
        $display("FAIL %s_beat%0d: got data %0h resp %0b last %0b, expected data %0h resp %0b last %0b",
                 name, b, rbuf[b], rrbuf[b], rlbuf[b], model[beat_word(word, burst, b)], resp, b == len);
      else passes++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; tick(); tick();
    checks++; if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0)
      $display("FAIL reset_valids: got %b expected 000000", {awready, wready, bvalid, arready, rvalid, rlast}); else passes++;
    checks++; if ({bid, bresp, rid, rresp} !== 12'h0)
      $display("FAIL reset_ids: got %h expected 000", {bid, bresp, rid, rresp}); else passes++;
    checks++; if (rdata !== '0) $display("FAIL reset_rdata: got %h expected 0", rdata); else passes++;
    resetn = 1'b1; tick();
  endtask

  task automatic test_single_write_read();
    for (int b = 0; b < 8; b++) begin wbuf[b] = DATA_W'(b); sbuf[b] = '1; end
    do_write(4'h3, 30'h40, 7, 2'd1, 3'd5, -1, 0);
    checks++; if (!ok || got_bresp !== 2'b00 || got_bid !== 4'h3)
      $display("FAIL single_bresp: got ok=%0b resp %b id %h, expected ok=1 resp 00 id 3", ok, got_bresp, got_bid); else passes++;
    checks++; if (t_wready != t_aw + 1) $display("FAIL single_wready_time: got %0d expected %0d", t_wready, t_aw + 1); else passes++;
    checks++; if (t_bvalid != t_after_w) $display("FAIL single_bvalid_time: got %0d expected %0d", t_bvalid, t_after_w); else passes++;
    tick();
    do_read(4'h5, 30'h40, 7, 2'd1, 3'd5, 0);
    checks++; if (t_rvalid != t_ar + 1) $display("FAIL single_rvalid_time: got %0d expected %0d", t_rvalid, t_ar + 1); else passes++;
    checks++; if (cyc != t_ar + 9) $display("FAIL single_burst_end: got %0d expected %0d", cyc, t_ar + 9); else passes++;
    checks++; if (nbeats != 8) $display("FAIL single_beats: got %0d expected 8", nbeats); else passes++;
    for (int b = 0; b < 8 && b < nbeats; b++) begin
      checks++;
      if (rbuf[b] !== DATA_W'(b) || rlbuf[b] !== (b == 7) || rrbuf[b] !== 2'b00)
        $display("FAIL single_beat%0d: got %0h last %0b resp %b, expected %0h last %0b resp 00", b, rbuf[b], rlbuf[b], rrbuf[b], b, b == 7);
      else passes++;
    end
  endtask

  task automatic test_strobes();
    logic [DATA_W-1:0] expect_word;
    wbuf[0] = '0; sbuf[0] = '1;
    do_write(4'h1, make_addr(10'd0), 0, 2'd1, 3'd5, -1, 0);
    wbuf[0] = '1; sbuf[0] = STRB_W'(32'h0000000F);
    do_write(4'h2, make_addr(10'd0), 0, 2'd1, 3'd5, -1, 0);
    do_read(4'h6, make_addr(10'd0), 0, 2'd1, 3'd5, 0);
    expect_word = '0; expect_word[31:0] = 32'hFFFF_FFFF;
    checks++; if (!ok || rbuf[0] !== expect_word)
      $display("FAIL strobe_word0: got %h expected %h", rbuf[0], expect_word); else passes++;
  endtask

  task automatic test_arbitration();
    int got, expect_first;
    bit last_write = 0;
    resetn = 1'b0; tick(); resetn = 1'b1; tick();
    for (int round = 0; round < 2; round++) begin
      fill(1, 0);
      awid = 4'(round + 8); awaddr = make_addr(10'd300); awlen = 4'd1; awburst = 2'd1; awsize = 3'd5;
      arid = 4'(round + 12); araddr = make_addr(10'd2); arlen = 4'd0; arburst = 2'd1; arsize = 3'd5;
      awvalid = 1'b1; arvalid = 1'b1;
      for (int k = 0; k < 2; k++) begin
        got = 2;
        for (int i = 0; i < 50 && got == 2; i++) begin
          if (awready) got = 0; else if (arready) got = 1;
          tick();
        end
        expect_first = last_write ? 1 : 0;
        checks++; if (got != expect_first)
          $display("FAIL arb_round%0d_grant%0d: got %0d expected %0d (0=write 1=read 2=none)", round, k, got, expect_first); else passes++;
        if (got == 0) begin
          awvalid = 1'b0; w_phase(1, -1); b_phase(0); model_write(10'd300, 1, 2'd1);
          checks++; if (!ok || got_bid !== 4'(round + 8)) $display("FAIL arb_bid: got %h expected %h", got_bid, 4'(round + 8)); else passes++;
          last_write = 1;
        end else if (got == 1) begin
          arvalid = 1'b0; r_phase(0);
          checks++; if (!ok || got_rid !== 4'(round + 12) || rbuf[0] !== model[2])
            $display("FAIL arb_read: got id %h data %h expected id %h data %h", got_rid, rbuf[0], 4'(round + 12), model[2]); else passes++;
          last_write = 0;
        end
      end
      awvalid = 1'b0; arvalid = 1'b0;
      tick();
    end
  endtask

  task automatic test_back_pressure();
    int len;
    logic [MEM_AW-1:0] word;
    for (int n = 0; n < 2; n++) begin
      len = 3 + int'($urandom_range(0, 9)); word = MEM_AW'($urandom_range(400, 900));
      fill(len, 0);
      do_write(4'(n), make_addr(word), len, 2'd1, 3'd5, -1, 1);
      checks++; if (!ok || got_bresp !== 2'b00 || unstable != 0)
        $display("FAIL bp_write%0d: got ok=%0b resp %b unstable %0d expected ok=1 resp 00 unstable 0", n, ok, got_bresp, unstable); else passes++;
      read_and_compare("bp_read", 4'(n + 4), word, len, 2'd1, 2'b00, 1);
      checks++; if (unstable != 0) $display("FAIL bp_read_hold: got %0d changes expected 0", unstable); else passes++;
    end
  endtask

  task automatic test_errors();
    fill(3, 0);
    do_write(4'h7, make_addr(10'd100), 3, 2'd2, 3'd5, -1, 0);
    checks++; if (!ok || got_bresp !== exp_resp(2'd2, 3'd5, -1, 3)) $display("FAIL err_wrap_bresp: got %b expected 10", got_bresp); else passes++;
    read_and_compare("err_wrap_read", 4'h8, 10'd100, 3, 2'd2, 2'b10, 0);
    read_and_compare("err_wrap_data", 4'h9, 10'd100, 3, 2'd1, 2'b00, 0);
    fill(3, 0);
    do_write(4'hA, make_addr(10'd120), 3, 2'd1, 3'd5, 1, 0);
    checks++; if (!ok || got_bresp !== exp_resp(2'd1, 3'd5, 1, 3)) $display("FAIL err_early_wlast: got %b expected 10", got_bresp); else passes++;
    read_and_compare("err_early_data", 4'hB, 10'd120, 3, 2'd1, 2'b00, 0);
    fill(0, 0);
    do_write(4'hC, make_addr(10'd130), 0, 2'd1, 3'd3, -1, 0);
    checks++; if (!ok || got_bresp !== exp_resp(2'd1, 3'd3, -1, 0)) $display("FAIL err_size: got %b expected 10", got_bresp); else passes++;
    fill(1, 0);
    do_write(4'hD, make_addr(10'd1023), 1, 2'd1, 3'd5, -1, 0);
    checks++; if (!ok || got_bresp !== 2'b00) $display("FAIL top_wrap_bresp: got %b expected 00", got_bresp); else passes++;
    do_read(4'hE, make_addr(10'd0), 0, 2'd1, 3'd5, 0);
    checks++; if (!ok || rbuf[0] !== wbuf[1]) $display("FAIL top_wrap_word0: got %h expected %h", rbuf[0], wbuf[1]); else passes++;
  endtask

  task automatic test_random();
    int len;
    logic [1:0] burst;
    logic [MEM_AW-1:0] word;
    for (int n = 0; n < 5; n++) begin
      len = int'($urandom_range(0, 7)); word = MEM_AW'($urandom_range(500, 1000));
      burst = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd1;
      fill(len, 0);
      do_write(4'(n), make_addr(word), len, 2'd1, 3'd5, -1, 0);
      fill(len, 1);
      do_write(4'(n + 1), make_addr(word), len, burst, 3'd5, -1, 1'($urandom));
      checks++; if (!ok || got_bresp !== 2'b00 || got_bid !== 4'(n + 1))
        $display("FAIL rand%0d_bresp: got resp %b id %h expected 00 id %h", n, got_bresp, got_bid, 4'(n + 1)); else passes++;
      read_and_compare("rand_incr", 4'(n + 2), word, len, 2'd1, 2'b00, 1'($urandom));
      read_and_compare("rand_same", 4'(n + 3), word, len, burst, 2'b00, 0);
    end
  endtask

  task automatic test_reset_mid_burst();
    ar_phase(4'h4, make_addr(10'd2), 7, 2'd1, 3'd5);
    rready = 1'b1;
    tick(); tick(); tick();
    checks++; if (rvalid !== 1'b1 || rdata !== model[5]) $display("FAIL midrst_beat3: got valid %b data %h expected 1 %h", rvalid, rdata, model[5]); else passes++;
    resetn = 1'b0; tick();
    checks++; if ({rvalid, rlast, arready, awready} !== 4'b0 || rdata !== '0)
      $display("FAIL midrst_outputs: got %b data %h expected 0000 0", {rvalid, rlast, arready, awready}, rdata); else passes++;
    resetn = 1'b1; rready = 1'b0; tick();
    read_and_compare("midrst_after", 4'h9, 10'd2, 7, 2'd1, 2'b00, 0);
    checks++; if (t_rvalid != t_ar + 1) $display("FAIL midrst_rvalid_time: got %0d expected %0d", t_rvalid, t_ar + 1); else passes++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_single_write_read();
    test_strobes();
    test_arbitration();
    test_back_pressure();
    test_errors();
    test_random();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axi4_slave_mem.md
# axi4_slave_mem

AXI4 responder that models the DDR side of the frame-buffer path: it accepts write and read bursts from the frame-buffer AXI4 master and stores them in an internal byte-enabled RAM. It is used as the memory endpoint in simulation and in on-chip loopback builds, where it replaces the DDR controller. It serves one transaction at a time and arbitrates fairly between the write and read channels.

## Interface
- DATA_W, 256, data bus width in bits; power of two, at least 32
- ADDR_W, 30, byte address width
- ID_W, 4, transaction ID width
- MEM_AW, 10, RAM depth is 2^MEM_AW words of DATA_W bits

Ports:
- axi_clk  in  1  single clock
- axi_resetn  in  1  synchronous, active-low reset
- axi_awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/4/3/2  write address; lock/cache/prot/qos are ignored
- axi_awvalid in 1; axi_awready out 1
- axi_wdata in DATA_W; axi_wstrb in DATA_W/8; axi_wlast in 1; axi_wvalid in 1; axi_wready out 1
- axi_bid out ID_W; axi_bresp out 2; axi_bvalid out 1; axi_bready in 1
- axi_arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/4/3/2  read address
- axi_arvalid in 1; axi_arready out 1
- axi_rid out ID_W; axi_rdata out DATA_W; axi_rresp out 2; axi_rlast out 1; axi_rvalid out 1; axi_rready in 1

## Operation
- States:
  - IDLE
  - AW_ACK → WDATA → WRESP → IDLE
  - AR_ACK → RDATA → IDLE
- IDLE:
  - If only awvalid is high, go to AW_ACK. If only arvalid is high, go to AR_ACK.
  - If both are high, grant the channel that was not granted last. After reset, write has priority.
- AW_ACK / AR_ACK:
  - Drive the matching ready high for exactly this one cycle.
  - Capture id, word address, len and burst.
  - Word address is addr[MEM_AW+B-1:B], where B = log2(DATA_W/8). The low B address bits are ignored.
- WDATA:
  - wready = 1.
  - On each beat handshake, write every byte lane whose wstrb bit is set, then advance the address.
  - The beat counter runs from 0 to awlen. The beat where the counter equals awlen is the last beat; move to WRESP after it.
- WRESP:
  - bvalid = 1; bid = captured id.
  - Hold bid and bresp until bready is high, then return to IDLE.
- RDATA:
  - rvalid = 1; rid = captured id.
  - rlast is high on beat awlen (arlen).
  - Hold rdata, rlast and rresp while rready is low.
  - After the handshake with rlast high, return to IDLE.
- Address advance:
  - INCR: +1, wrapping modulo 2^MEM_AW.
  - FIXED: hold the address.
  - WRAP: treated as INCR, and the response is SLVERR.
- Response codes:
  - OKAY (2'b00) by default.
  - SLVERR (2'b10) if burst is WRAP or reserved, if size ≠ log2(DATA_W/8), or if wlast does not match the final beat.
  - Errors never abort the burst; it runs to completion.
  - A write's SLVERR appears on bresp. A read's SLVERR appears on every R beat.

## Timing
- Reset values: awready, wready, bvalid, arready, rvalid and rlast = 0; bid, bresp, rid, rresp and rdata = 0; state = IDLE; priority = write.
- RAM contents are not reset.
- Write path:
  - AW handshake at cycle T; wready first high at T+1.
  - bvalid is high in the cycle after the last W handshake.
- Read path:
  - AR handshake at cycle T; rvalid with beat 0 at T+1.
  - With rready held high: one beat per cycle, so a burst of len+1 beats completes at T+1+len.
- Minimum gap between transactions: after returning to IDLE, the next ready pulse comes 1 cycle later.
- Reset mid-burst: at the next edge all outputs take their reset values and the in-flight transaction is dropped.

## Structure
- Shared package axi4_pkg:
  - burst encodings: FIXED = 0, INCR = 1, WRAP = 2
  - response codes: OKAY, SLVERR
  - state enum
- Sub-module axi4_slave_ram:
  - single port, byte-write-enable
  - synchronous read, 1-cycle latency
  - the RDATA path issues each read one cycle ahead so the next beat is ready when needed

## Test plan
- Single write then read:
  - Stimulus: INCR write, awaddr 0x40, awlen 7, beats 0..7, all strobes set; then an AR to the same address.
  - Expected: bresp 0; rdata beats 0..7; rlast only on the 8th beat; rvalid at T+1.
- Strobes:
  - Stimulus: write 0xFF.. to word 0 with wstrb 0x0000000F, after word 0 was zeroed.
  - Expected: read returns only the low 4 bytes = 0xFF.
- Simultaneous AW and AR:
  - Stimulus: assert AW and AR together twice in a row.
  - Expected: write granted first, read second, then alternation; both IDs echoed correctly.
- Back-pressure:
  - Stimulus: toggle rready and bready every other cycle.
  - Expected: data held stable while ready is low; no beat lost; beat count = len+1.
- Error cases:
  - Stimulus: WRAP burst, and an early wlast.
  - Expected: bresp/rresp = 2'b10; data still written.
  - Stimulus: INCR write at the top word 2^MEM_AW−1 with len 1.
  - Expected: second beat lands at word 0.
- Reset mid-burst:
  - Stimulus: pull axi_resetn low during beat 3 of a read.
  - Expected: next edge rvalid = 0 and state IDLE; a new AR is then served normally.
